// File: rtl/ps2_key_decoder_pkg.sv
// rtl/ps2_key_decoder_pkg.sv - Scan-code constants, action indices and FSM encoding for the PS/2 key decoder.
package ps2_key_decoder_pkg;

    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam logic [7:0] SC_BRK       = 8'hF0;
    localparam logic [7:0] SC_PAUSE_SEQ = 8'hE1;

    localparam logic [7:0] SC_ERR0      = 8'h00;
    localparam logic [7:0] SC_BAT_OK    = 8'hAA;
    localparam logic [7:0] SC_ECHO      = 8'hEE;
    localparam logic [7:0] SC_ACK       = 8'hFA;
    localparam logic [7:0] SC_BAT_FAIL  = 8'hFC;
    localparam logic [7:0] SC_RESEND    = 8'hFE;
    localparam logic [7:0] SC_ERR1      = 8'hFF;

    localparam logic [7:0] SC_P1_UP     = 8'h1D;
    localparam logic [7:0] SC_P1_DOWN   = 8'h1B;
    localparam logic [7:0] SC_P1_LEFT   = 8'h1C;
    localparam logic [7:0] SC_P1_RIGHT  = 8'h23;
    localparam logic [7:0] SC_P1_BOMB   = 8'h29;
    localparam logic [7:0] SC_P2_UP     = 8'h75;
    localparam logic [7:0] SC_P2_DOWN   = 8'h72;
    localparam logic [7:0] SC_P2_LEFT   = 8'h6B;
    localparam logic [7:0] SC_P2_RIGHT  = 8'h74;
    localparam logic [7:0] SC_P2_BOMB   = 8'h5A;
    localparam logic [7:0] SC_ESC       = 8'h76;

    localparam logic [2:0] ACT_UP    = 3'd0;
    localparam logic [2:0] ACT_DOWN  = 3'd1;
    localparam logic [2:0] ACT_LEFT  = 3'd2;
    localparam logic [2:0] ACT_RIGHT = 3'd3;
    localparam logic [2:0] ACT_BOMB  = 3'd4;
    localparam logic [2:0] ACT_PAUSE = 3'd5;

    // Bytes still to swallow after E1 (Pause/Break sends E1 plus seven more).
    localparam logic [2:0] SKIP_LEN = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_t;

    typedef struct packed {
        logic       hit;
        logic       player;
        logic [2:0] action;
    } key_hit_t;

    function automatic logic is_control(input logic [7:0] b);
        return (b == SC_ERR0) || (b == SC_BAT_OK) || (b == SC_ECHO) || (b == SC_ACK) ||
               (b == SC_BAT_FAIL) || (b == SC_RESEND) || (b == SC_ERR1);
    endfunction

    function automatic key_hit_t map_key(input logic [7:0] code, input logic ext);
        key_hit_t r;
        r = '0;
        if (ext) begin
            case (code)
                SC_P2_UP:    r = '{1'b1, 1'b1, ACT_UP};
                SC_P2_DOWN:  r = '{1'b1, 1'b1, ACT_DOWN};
                SC_P2_LEFT:  r = '{1'b1, 1'b1, ACT_LEFT};
                SC_P2_RIGHT: r = '{1'b1, 1'b1, ACT_RIGHT};
                default:     r = '0;
            endcase
        end else begin
            case (code)
                SC_P1_UP:    r = '{1'b1, 1'b0, ACT_UP};
                SC_P1_DOWN:  r = '{1'b1, 1'b0, ACT_DOWN};
                SC_P1_LEFT:  r = '{1'b1, 1'b0, ACT_LEFT};
                SC_P1_RIGHT: r = '{1'b1, 1'b0, ACT_RIGHT};
                SC_P1_BOMB:  r = '{1'b1, 1'b0, ACT_BOMB};
                SC_P2_BOMB:  r = '{1'b1, 1'b1, ACT_BOMB};
                default:     r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_timeout.sv
// rtl/ps2_timeout.sv - Inactivity counter; expire is high in the LIMIT-th idle cycle while enabled.
module ps2_timeout #(
    parameter int LIMIT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    assign expire = enable && (count == W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear || !enable || expire) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 byte decoder producing two-player held key maps, pause and change events.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_valid,
    input  logic [7:0] scan_byte,
    output logic [4:0] p1_keys,
    output logic [4:0] p2_keys,
    output logic       pause,
    output logic       evt_valid,
    output logic       evt_player,
    output logic [2:0] evt_action,
    output logic       evt_pressed
);

    state_t     state;
    logic [2:0] skip_cnt;
    logic       expire;
    logic       ext;
    logic       brk;
    key_hit_t   hit;
    logic [4:0] mask;
    logic [4:0] sel_keys;
    logic       cur_bit;

    assign ext      = (state == ST_EXT) || (state == ST_EXT_BRK);
    assign brk      = (state == ST_BRK) || (state == ST_EXT_BRK);
    assign hit      = map_key(scan_byte, ext);
    assign mask     = 5'b00001 << hit.action;
    assign sel_keys = hit.player ? p2_keys : p1_keys;
    assign cur_bit  = |(sel_keys & mask);

    ps2_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (scan_valid),
        .enable (state != ST_IDLE),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            skip_cnt    <= '0;
            p1_keys     <= '0;
            p2_keys     <= '0;
            pause       <= 1'b0;
            evt_valid   <= 1'b0;
            evt_player  <= 1'b0;
            evt_action  <= '0;
            evt_pressed <= 1'b0;
        end else begin
            evt_valid <= 1'b0;
            if (scan_valid) begin
                if (state == ST_SKIP) begin
                    skip_cnt <= skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        state <= ST_IDLE;
                    end
                end else if (scan_byte == SC_PAUSE_SEQ) begin
                    state    <= ST_SKIP;
                    skip_cnt <= SKIP_LEN;
                end else if (scan_byte == SC_EXT) begin
                    state <= brk ? ST_EXT_BRK : ST_EXT;
                end else if (scan_byte == SC_BRK) begin
                    state <= ext ? ST_EXT_BRK : ST_BRK;
                end else if (is_control(scan_byte)) begin
                    state <= ST_IDLE;
                    // Keyboard self-test passed: it was just (re)plugged, so nothing can be held.
                    if (scan_byte == SC_BAT_OK) begin
                        p1_keys <= '0;
                        p2_keys <= '0;
                    end
                end else begin
                    state <= ST_IDLE;
                    if (!ext && scan_byte == SC_ESC) begin
                        if (!brk) begin
                            pause       <= ~pause;
                            evt_valid   <= 1'b1;
                            evt_player  <= 1'b0;
                            evt_action  <= ACT_PAUSE;
                            evt_pressed <= 1'b1;
                        end
                    end else if (hit.hit && (cur_bit == brk)) begin
                        // Bit differs from the requested level, so this is a real change.
                        if (hit.player) begin
                            p2_keys <= brk ? (p2_keys & ~mask) : (p2_keys | mask);
                        end else begin
                            p1_keys <= brk ? (p1_keys & ~mask) : (p1_keys | mask);
                        end
                        evt_valid   <= 1'b1;
                        evt_player  <= hit.player;
                        evt_action  <= hit.action;
                        evt_pressed <= ~brk;
                    end
                end
            end else if (expire) begin
                state    <= ST_IDLE;
                skip_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - Directed self-checking bench for ps2_key_decoder.
module tb_ps2_key_decoder;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_valid;
    logic [7:0] scan_byte;
    logic [4:0] p1_keys;
    logic [4:0] p2_keys;
    logic       pause;
    logic       evt_valid;
    logic       evt_player;
    logic [2:0] evt_action;
    logic       evt_pressed;

    int errors    = 0;
    int checks    = 0;
    int evt_count = 0;
    int base;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_valid  (scan_valid),
        .scan_byte   (scan_byte),
        .p1_keys     (p1_keys),
        .p2_keys     (p2_keys),
        .pause       (pause),
        .evt_valid   (evt_valid),
        .evt_player  (evt_player),
        .evt_action  (evt_action),
        .evt_pressed (evt_pressed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (evt_valid) evt_count++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_valid = 1'b1;
        scan_byte  = b;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        scan_valid = 1'b0;
        scan_byte  = 8'h00;
        idle(3);
        check("rst_p1", p1_keys, 5'b00000);
        check("rst_p2", p2_keys, 5'b00000);
        check("rst_pause", pause, 1'b0);
        check("rst_evt", {evt_valid, evt_player, evt_action, evt_pressed}, 6'b0);
        @(negedge clk);
        rst = 1'b0;

        // P1 up make then break
        send(8'h1D);
        check("w_make_p1", p1_keys, 5'b00001);
        check("w_make_evt", {evt_valid, evt_player, evt_action, evt_pressed}, {1'b1, 1'b0, 3'd0, 1'b1});
        send(8'hF0);
        check("f0_no_evt", evt_valid, 1'b0);
        check("f0_p1_held", p1_keys, 5'b00001);
        send(8'h1D);
        check("w_brk_p1", p1_keys, 5'b00000);
        check("w_brk_evt", {evt_valid, evt_player, evt_action, evt_pressed}, {1'b1, 1'b0, 3'd0, 1'b0});
        idle(1);
        check("evt_hold", {evt_valid, evt_player, evt_action, evt_pressed}, {1'b0, 1'b0, 3'd0, 1'b0});

        // Opposing directions held together
        send(8'h1D);
        send(8'h1B);
        check("p1_up_down", p1_keys, 5'b00011);
        send(8'hF0); send(8'h1D);
        send(8'hF0); send(8'h1B);
        check("p1_clear", p1_keys, 5'b00000);

        // P2 right with typematic repeat
        idle(1);
        base = evt_count;
        send(8'hE0); send(8'h74);
        check("p2_right_make", p2_keys, 5'b01000);
        check("p2_right_evt", {evt_valid, evt_player, evt_action, evt_pressed}, {1'b1, 1'b1, 3'd3, 1'b1});
        send(8'hE0); send(8'h74);
        check("p2_repeat_no_evt", evt_valid, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h74);
        check("p2_right_brk", p2_keys, 5'b00000);
        check("p2_right_brk_pressed", evt_pressed, 1'b0);
        idle(1);
        check("p2_evt_total", evt_count - base, 2);
        base = evt_count;
        send(8'h75);
        idle(1);
        check("75_no_ext_p2", p2_keys, 5'b00000);
        check("75_no_ext_evt", evt_count - base, 0);

        // Pause/Break sequence swallowed, then Space
        base = evt_count;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        idle(1);
        check("e1_no_evt", evt_count - base, 0);
        send(8'h29);
        check("space_p1", p1_keys, 5'b10000);
        check("space_evt", {evt_valid, evt_player, evt_action, evt_pressed}, {1'b1, 1'b0, 3'd4, 1'b1});
        idle(1);
        check("space_evt_total", evt_count - base, 1);

        // Extended qualifier must match
        send(8'hE0); send(8'h1D);
        check("e0_1d_ignored", p1_keys, 5'b10000);

        // Timeout expired: prefix dropped
        send(8'hE0);
        idle(TO);
        base = evt_count;
        send(8'h75);
        idle(1);
        check("timeout_p2", p2_keys, 5'b00000);
        check("timeout_evt", evt_count - base, 0);

        // Byte in the expiry cycle still uses the prefix
        send(8'hE0);
        idle(TO - 1);
        send(8'h75);
        check("edge_p2_up", p2_keys, 5'b00001);
        check("edge_evt", {evt_valid, evt_player, evt_action}, {1'b1, 1'b1, 3'd0});

        // AA clears maps silently; Esc toggles pause
        send(8'h1D);
        send(8'h5A);
        check("hold_p1", p1_keys, 5'b10001);
        check("hold_p2", p2_keys, 5'b10001);
        idle(1);
        base = evt_count;
        send(8'hAA);
        check("aa_p1", p1_keys, 5'b00000);
        check("aa_p2", p2_keys, 5'b00000);
        idle(1);
        check("aa_no_evt", evt_count - base, 0);
        send(8'h76);
        check("esc1_pause", pause, 1'b1);
        check("esc1_evt", {evt_valid, evt_action, evt_pressed}, {1'b1, 3'd5, 1'b1});
        send(8'hF0); send(8'h76);
        check("esc_brk_pause", pause, 1'b1);
        check("esc_brk_no_evt", evt_valid, 1'b0);
        send(8'h76);
        check("esc2_pause", pause, 1'b0);
        check("esc2_evt", {evt_valid, evt_action}, {1'b1, 3'd5});

        // Reset overrides a strobe and discards the F0 prefix
        send(8'h1D);
        send(8'hF0);
        @(negedge clk);
        rst        = 1'b1;
        scan_valid = 1'b1;
        scan_byte  = 8'h1D;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        scan_valid = 1'b0;
        check("rst_pri_p1", p1_keys, 5'b00000);
        check("rst_pri_evt", evt_valid, 1'b0);
        send(8'h1D);
        check("post_rst_make", p1_keys, 5'b00001);
        check("post_rst_pressed", {evt_valid, evt_pressed}, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, clk cycles a prefix/skip state may wait for its next byte before abandoning it (1 ms at 50 MHz).
REQ-002 clk  input  1  single clock; same 50 MHz domain as the PS/2 receiver.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 scan_valid  input  1  one-cycle strobe; scan_byte is valid in that cycle.
REQ-005 scan_byte  input  8  one received PS/2 set-2 scan byte.
REQ-006 p1_keys  output  5  held state for player 1: bit0 up, bit1 down, bit2 left, bit3 right, bit4 bomb.
REQ-007 p2_keys  output  5  held state for player 2, same bit order.
REQ-008 pause  output  1  level; toggles on each Esc press.
REQ-009 evt_valid  output  1  one-cycle pulse when any held bit or pause changes.
REQ-010 evt_player  output  1  0 = player 1, 1 = player 2; not meaningful for pause events.
REQ-011 evt_action  output  3  0..4 = bit index above; 5 = pause.
REQ-012 evt_pressed  output  1  1 = make, 0 = break.

Function
REQ-013 Key map: P1 W=1D, S=1B, A=1C, D=23, Space=29 (non-extended); P2 up E0 75, down E0 72, left E0 6B, right E0 74, bomb = Enter 5A (non-extended); Esc = 76 (non-extended).
REQ-014 FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
REQ-015 E0: IDLE->EXT, BRK->EXT_BRK, EXT and EXT_BRK unchanged.
REQ-016 F0: IDLE->BRK, EXT->EXT_BRK, BRK and EXT_BRK unchanged.
REQ-017 E1 in any non-SKIP state: enter SKIP, load skip counter with 7; each later byte decrements it; the byte taking it to 0 returns FSM to IDLE; no events generated.
REQ-018 Control bytes 00, AA, EE, FA, FC, FE, FF in any non-SKIP state: return to IDLE, no event; AA additionally clears p1_keys and p2_keys in the same cycle, without events.
REQ-019 Any other byte is a key code, decoded with extended = (state in EXT/EXT_BRK) and break = (state in BRK/EXT_BRK); FSM then returns to IDLE.
REQ-020 A key code matches only with the correct extended qualifier; unmapped codes are dropped silently.
REQ-021 A mapped make sets its bit and a break clears it; evt_valid is asserted only if the bit changes, so typematic repeats produce no event.
REQ-022 Esc make toggles pause with an event; Esc break has no effect.
REQ-023 Latency: byte strobed at cycle t -> key bits, pause and event outputs registered at t+1.
REQ-024 Timeout counter clears on every scan_valid; in EXT, BRK, EXT_BRK or SKIP, after TIMEOUT_CYCLES cycles with no byte, FSM -> IDLE with no event.
REQ-025 If timeout expiry and scan_valid occur in the same cycle, the byte is processed in the current state and the timeout is ignored.
REQ-026 P1 and P2 keys are independent; opposing directions may both be held, and the decoder does not arbitrate.
REQ-027 evt_player, evt_action and evt_pressed hold their last values when evt_valid = 0.

Reset
REQ-028 On rst: FSM IDLE, skip and timeout counters 0, p1_keys = 0, p2_keys = 0, pause = 0, evt_valid = 0, evt_player = 0, evt_action = 0, evt_pressed = 0.
REQ-029 rst has priority over scan_valid in the same cycle; a partly received prefix sequence is discarded.

Structure
REQ-030 A shared package holds the scan-code constants (prefixes, control bytes, mapped keys), the action index constants and the FSM state encoding; the player/game logic reuses these.
REQ-031 The timeout counter is one natural sub-module, ps2_timeout, with clear and expire signals; everything else is flat.

Verification
REQ-032 Bytes 1D then F0 1D: p1_keys 00000 -> 00001 -> 00000; two events (player 0, action 0, pressed 1/0), each one cycle after its byte.
REQ-033 Bytes E0 74, E0 74, E0 F0 74: p2_keys bit3 set once; only 2 events in total; 75 without E0 leaves p2_keys unchanged.
REQ-034 Bytes E1 14 77 E1 F0 14 F0 77 then 29: no event during the sequence; then p1 bit4 set with one event.
REQ-035 E0, then TIMEOUT_CYCLES idle cycles, then 75: the byte is decoded as non-extended; no P2 up event.
REQ-036 Hold 1D and 5A, then send AA: both maps clear to 0 with no event; then 76 twice: pause 0 -> 1 -> 0 with two events, action 5.
REQ-037 Send F0, then assert rst together with the 1D strobe, then send 1D: result is a make (bit0 set), proving the prefix was discarded.
